// File: rtl/ddr_cmd_issuer.sv
// DDR4 controller-side command issuer: one request at a time, single open row.
// Ports: CK_t/reset, req_* handshake in, DDR4 CA pins out, no_act_rdy/cas_done pulses.
module ddr_cmd_issuer #(
    parameter int T_RP  = 4,
    parameter int T_RCD = 4,
    parameter int T_RAS = 10,
    parameter int T_CCD = 4,
    parameter int T_RTP = 4,
    parameter int T_WTP = 16
) (
    input  logic        CK_t,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic        req_bl4,
    input  logic [1:0]  req_bg,
    input  logic [1:0]  req_ba,
    input  logic [13:0] req_row,
    input  logic [9:0]  req_col,
    output logic        cs_n,
    output logic        act_n,
    output logic        RAS_n_A16,
    output logic        CAS_n_A15,
    output logic        WE_n_A14,
    output logic [1:0]  bg_addr,
    output logic [1:0]  ba_addr,
    output logic        A13,
    output logic        A12_BC_n,
    output logic        A11,
    output logic        A10_AP,
    output logic [9:0]  A9_A0,
    output logic        no_act_rdy,
    output logic        cas_done
);

    localparam int CNT_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT_RP,
        S_ACT,
        S_WAIT_RCD,
        S_CAS,
        S_WAIT_CCD
    } state_t;

    typedef enum logic [2:0] {
        C_DES,
        C_ACT,
        C_RD,
        C_WR,
        C_PRE
    } cmd_t;

    state_t state_q, state_d;
    cmd_t   cmd_d;

    logic        r_wr, r_bl4;
    logic [1:0]  r_bg, r_ba;
    logic [13:0] r_row;
    logic [9:0]  r_col;
    logic        hit_q;

    logic        open_valid;
    logic [1:0]  open_bg, open_ba;
    logic [13:0] open_row;

    logic [CNT_W-1:0] rp_cnt, rcd_cnt, ras_cnt, ccd_cnt, pg_cnt;
    logic [CNT_W-1:0] pg_nx, pg_ld;

    logic accept, hit;

    logic [4:0]  pins_d;
    logic [1:0]  bg_d, ba_d;
    logic [13:0] addr_d;

    assign accept = req_valid && req_ready;
    assign hit    = open_valid && (req_bg == open_bg) &&
                    (req_ba == open_ba) && (req_row == open_row);

    // Pre-guard follows the later of the running deadline and the new one.
    assign pg_nx = (pg_cnt != '0) ? pg_cnt - 1'b1 : '0;
    always_comb begin
        pg_ld = r_wr ? CNT_W'(T_WTP - 1) : CNT_W'(T_RTP - 1);
        if (pg_nx > pg_ld)
            pg_ld = pg_nx;
    end

    // Next state and command; a command is registered on the edge leaving
    // its issuing state.  The wait states exit one cycle early so the
    // counter reaches 0 exactly as the issuing state is entered.
    always_comb begin
        state_d = state_q;
        cmd_d   = C_DES;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (hit)
                        state_d = S_CAS;
                    else if (open_valid)
                        state_d = S_PRE;
                    else
                        state_d = S_ACT;
                end
            end
            S_PRE: begin
                if (ras_cnt == '0 && pg_cnt == '0) begin
                    cmd_d   = C_PRE;
                    state_d = S_WAIT_RP;
                end
            end
            S_WAIT_RP: begin
                if (rp_cnt <= CNT_W'(1))
                    state_d = S_ACT;
            end
            S_ACT: begin
                cmd_d   = C_ACT;
                state_d = S_WAIT_RCD;
            end
            S_WAIT_RCD: begin
                if (rcd_cnt <= CNT_W'(1))
                    state_d = S_CAS;
            end
            S_CAS: begin
                if (ccd_cnt == '0) begin
                    cmd_d   = r_wr ? C_WR : C_RD;
                    state_d = S_WAIT_CCD;
                end
            end
            S_WAIT_CCD: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Pin image of the command about to be registered.
    always_comb begin
        pins_d = 5'b11111;
        bg_d   = '0;
        ba_d   = '0;
        addr_d = '0;
        unique case (cmd_d)
            C_ACT: begin
                pins_d = 5'b00111;
                bg_d   = r_bg;
                ba_d   = r_ba;
                addr_d = r_row;
            end
            C_RD, C_WR: begin
                pins_d = (cmd_d == C_WR) ? 5'b01100 : 5'b01101;
                bg_d   = r_bg;
                ba_d   = r_ba;
                addr_d = {1'b0, !r_bl4, 2'b00, r_col};
            end
            C_PRE: begin
                pins_d = 5'b01010;
                bg_d   = open_bg;
                ba_d   = open_ba;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CK_t) begin
        if (reset) begin
            state_q    <= S_IDLE;
            req_ready  <= 1'b0;
            r_wr       <= 1'b0;
            r_bl4      <= 1'b0;
            r_bg       <= '0;
            r_ba       <= '0;
            r_row      <= '0;
            r_col      <= '0;
            hit_q      <= 1'b0;
            open_valid <= 1'b0;
            open_bg    <= '0;
            open_ba    <= '0;
            open_row   <= '0;
            rp_cnt     <= '0;
            rcd_cnt    <= '0;
            ras_cnt    <= '0;
            ccd_cnt    <= '0;
            pg_cnt     <= '0;
        end else begin
            state_q   <= state_d;
            req_ready <= (state_d == S_IDLE);

            if (accept) begin
                r_wr  <= req_wr;
                r_bl4 <= req_bl4;
                r_bg  <= req_bg;
                r_ba  <= req_ba;
                r_row <= req_row;
                r_col <= req_col;
                hit_q <= hit;
            end

            rp_cnt  <= (rp_cnt  != '0) ? rp_cnt  - 1'b1 : '0;
            rcd_cnt <= (rcd_cnt != '0) ? rcd_cnt - 1'b1 : '0;
            ras_cnt <= (ras_cnt != '0) ? ras_cnt - 1'b1 : '0;
            ccd_cnt <= (ccd_cnt != '0) ? ccd_cnt - 1'b1 : '0;
            pg_cnt  <= pg_nx;

            unique case (cmd_d)
                C_PRE: begin
                    open_valid <= 1'b0;
                    rp_cnt     <= CNT_W'(T_RP - 1);
                end
                C_ACT: begin
                    open_valid <= 1'b1;
                    open_bg    <= r_bg;
                    open_ba    <= r_ba;
                    open_row   <= r_row;
                    rcd_cnt    <= CNT_W'(T_RCD - 1);
                    ras_cnt    <= CNT_W'(T_RAS - 1);
                end
                C_RD, C_WR: begin
                    ccd_cnt <= CNT_W'(T_CCD - 1);
                    pg_cnt  <= pg_ld;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CK_t) begin
        if (reset) begin
            {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} <= 5'b11111;
            bg_addr    <= '0;
            ba_addr    <= '0;
            {A13, A12_BC_n, A11, A10_AP, A9_A0} <= '0;
            no_act_rdy <= 1'b0;
            cas_done   <= 1'b0;
        end else begin
            {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} <= pins_d;
            bg_addr    <= bg_d;
            ba_addr    <= ba_d;
            {A13, A12_BC_n, A11, A10_AP, A9_A0} <= addr_d;
            cas_done   <= (cmd_d == C_RD) || (cmd_d == C_WR);
            no_act_rdy <= ((cmd_d == C_RD) || (cmd_d == C_WR)) && hit_q;
        end
    end

endmodule

// File: tb/tb_ddr_cmd_issuer.sv
// Randomized bench for ddr_cmd_issuer against a command-schedule model.
// The model predicts each command's pins, bank, address and issue cycle.
module tb_ddr_cmd_issuer;

    localparam int T_RP  = 4;
    localparam int T_RCD = 4;
    localparam int T_RAS = 10;
    localparam int T_CCD = 4;
    localparam int T_RTP = 4;
    localparam int T_WTP = 16;
    localparam int NEG   = -1000;

    logic        CK_t = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic        req_bl4 = 1'b0;
    logic [1:0]  req_bg = '0;
    logic [1:0]  req_ba = '0;
    logic [13:0] req_row = '0;
    logic [9:0]  req_col = '0;
    logic        cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
    logic [1:0]  bg_addr, ba_addr;
    logic        A13, A12_BC_n, A11, A10_AP;
    logic [9:0]  A9_A0;
    logic        no_act_rdy, cas_done;

    ddr_cmd_issuer dut (
        .CK_t(CK_t), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_bl4(req_bl4),
        .req_bg(req_bg), .req_ba(req_ba),
        .req_row(req_row), .req_col(req_col),
        .cs_n(cs_n), .act_n(act_n),
        .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14),
        .bg_addr(bg_addr), .ba_addr(ba_addr),
        .A13(A13), .A12_BC_n(A12_BC_n), .A11(A11), .A10_AP(A10_AP),
        .A9_A0(A9_A0),
        .no_act_rdy(no_act_rdy), .cas_done(cas_done)
    );

    always #5 CK_t = ~CK_t;

    int cyc = 0;
    always @(posedge CK_t) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, exp);
        end
    endtask

    // kind: 0 ACT, 1 RD, 2 WR, 3 PRE
    typedef struct {
        int          kind;
        int          t;
        logic [1:0]  bg;
        logic [1:0]  ba;
        logic [13:0] addr;
        logic        hit;
    } exp_t;

    exp_t q[$];

    logic        m_open;
    logic [1:0]  m_bg, m_ba;
    logic [13:0] m_row;
    int l_act, l_rd, l_wr, l_cas, l_pre;
    logic acc;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [4:0] pins_of(input int kind);
        case (kind)
            0:       return 5'b00111;
            1:       return 5'b01101;
            2:       return 5'b01100;
            default: return 5'b01010;
        endcase
    endfunction

    task automatic model_flush();
        q.delete();
        m_open = 1'b0;
        m_bg = '0; m_ba = '0; m_row = '0;
        l_act = NEG; l_rd = NEG; l_wr = NEG; l_cas = NEG; l_pre = NEG;
    endtask

    // Schedule the commands one accepted request produces, each at the
    // earliest cycle all timing rules allow.
    task automatic model_accept(input int a);
        exp_t e;
        int tp, ta, tc;
        logic h;
        h = m_open && req_bg == m_bg && req_ba == m_ba && req_row == m_row;
        if (h) begin
            tc = imax(a + 1, l_cas + T_CCD);
        end else begin
            if (m_open) begin
                tp = imax(imax(a + 1, l_act + T_RAS),
                          imax(l_rd + T_RTP, l_wr + T_WTP));
                e = '{kind: 3, t: tp, bg: m_bg, ba: m_ba, addr: '0, hit: 1'b0};
                q.push_back(e);
                l_pre = tp;
                ta = tp + T_RP;
            end else begin
                ta = imax(a + 1, l_pre + T_RP);
            end
            e = '{kind: 0, t: ta, bg: req_bg, ba: req_ba, addr: req_row, hit: 1'b0};
            q.push_back(e);
            l_act = ta;
            tc = imax(ta + T_RCD, l_cas + T_CCD);
            m_open = 1'b1;
            m_bg = req_bg; m_ba = req_ba; m_row = req_row;
        end
        e = '{kind: req_wr ? 2 : 1, t: tc, bg: req_bg, ba: req_ba,
              addr: {1'b0, !req_bl4, 2'b00, req_col}, hit: h};
        q.push_back(e);
        l_cas = tc;
        if (req_wr) l_wr = tc; else l_rd = tc;
    endtask

    // One clock: note an accept on the coming edge, then inspect the bus.
    task automatic step();
        logic [4:0]  pins;
        logic [13:0] addr;
        exp_t e;
        acc = 1'b0;
        if (req_valid && req_ready && !reset) begin
            acc = 1'b1;
            model_accept(cyc + 1);
        end
        @(negedge CK_t);
        pins = {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14};
        addr = {A13, A12_BC_n, A11, A10_AP, A9_A0};
        if (pins[4] == 1'b0) begin
            if (q.size() == 0) begin
                check("unexpected_cmd", {27'd0, pins}, 32'h1f);
                check("cas_done_unexp", {31'd0, cas_done}, 32'd0);
            end else begin
                e = q.pop_front();
                check("cmd_pins", {27'd0, pins}, {27'd0, pins_of(e.kind)});
                check("cmd_cycle", cyc, e.t);
                check("bank", {28'd0, bg_addr, ba_addr}, {28'd0, e.bg, e.ba});
                check("addr", {18'd0, addr}, {18'd0, e.addr});
                check("cas_done", {31'd0, cas_done},
                      {31'd0, (e.kind == 1 || e.kind == 2)});
                check("no_act_rdy", {31'd0, no_act_rdy},
                      {31'd0, (e.kind == 1 || e.kind == 2) && e.hit});
            end
        end else begin
            check("des_cas_done", {31'd0, cas_done}, 32'd0);
            check("des_no_act_rdy", {31'd0, no_act_rdy}, 32'd0);
        end
    endtask

    task automatic issue(input logic wr, input logic bl4,
                         input logic [1:0] bg, input logic [1:0] ba,
                         input logic [13:0] row, input logic [9:0] col);
        req_valid = 1'b1;
        req_wr = wr; req_bl4 = bl4;
        req_bg = bg; req_ba = ba;
        req_row = row; req_col = col;
        step();
        for (int i = 0; i < 300 && !acc; i++) step();
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int pend;
        model_flush();
        reset = 1'b1;
        repeat (3) @(negedge CK_t);
        check("rst_bus", {27'd0, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14}, 32'h1f);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_addr", {16'd0, bg_addr, ba_addr, A13, A12_BC_n, A11, A10_AP, A9_A0}, 32'd0);
        reset = 1'b0;
        step();
        check("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // Fresh ACT, a BC4 hit back to back, then a row miss.
        issue(1'b1, 1'b0, 2'd1, 2'd2, 14'h155, 10'h3A);
        issue(1'b0, 1'b1, 2'd1, 2'd2, 14'h155, 10'h10);
        issue(1'b0, 1'b0, 2'd1, 2'd2, 14'h200, 10'h22);
        idle(20);

        // Write then a miss: PRE gated by write-to-precharge.
        issue(1'b1, 1'b0, 2'd1, 2'd2, 14'h200, 10'h05);
        issue(1'b0, 1'b0, 2'd3, 2'd3, 14'h3FFF, 10'h3FF);
        idle(30);

        // Reset while waiting on tRCD.
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_flush();
        step();
        issue(1'b0, 1'b0, 2'd0, 2'd1, 14'h0AA, 10'h001);
        req_valid = 1'b0;
        step();
        reset = 1'b1;
        model_flush();
        step();
        check("mid_rst_bus", {27'd0, cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14}, 32'h1f);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        step();
        check("mid_rst_ready_up", {31'd0, req_ready}, 32'd1);
        issue(1'b0, 1'b0, 2'd0, 2'd1, 14'h0AA, 10'h002);
        idle(20);

        // Requests held valid back to back, then with random gaps.
        for (int i = 0; i < 48; i++) begin
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 1)), 2'($urandom_range(0, 1)),
                  14'($urandom_range(0, 2)), 10'($urandom));
            if (i >= 8 && $urandom_range(0, 2) == 0)
                idle(int'($urandom_range(1, 12)));
        end

        req_valid = 1'b0;
        for (int i = 0; i < 300 && q.size() != 0; i++) step();
        idle(5);
        pend = q.size();
        check("drain", pend, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
